// File: rtl/ace_snoop_arbiter.sv
// Round-robin arbiter: NumReq snoop sources share one ACE AC/CR pair; AC registered (latency 1), CR routed in issue order.
// Optional ACE_SNOOP_ARB_ERRCHK_EN: sink stray CR beats and raise a sticky err_o on protocol errors.
module ace_snoop_arbiter #(
  parameter int NumReq         = 2,
  parameter int AddrWidth      = 64,
  parameter int MaxOutstanding = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_ac_valid_i,
  output logic [NumReq-1:0]         req_ac_ready_o,
  input  logic [NumReq*AddrWidth-1:0] req_ac_addr_i,
  input  logic [NumReq*4-1:0]       req_ac_snoop_i,
  input  logic [NumReq*3-1:0]       req_ac_prot_i,
  output logic                      ac_valid_o,
  input  logic                      ac_ready_i,
  output logic [AddrWidth-1:0]      ac_addr_o,
  output logic [3:0]                ac_snoop_o,
  output logic [2:0]                ac_prot_o,
  input  logic                      cr_valid_i,
  output logic                      cr_ready_o,
  input  logic [4:0]                cr_resp_i,
  output logic [NumReq-1:0]         req_cr_valid_o,
  input  logic [NumReq-1:0]         req_cr_ready_i,
  output logic [4:0]                req_cr_resp_o,
  output logic                      err_o
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic                 ac_valid_q, ac_valid_d;
  logic [AddrWidth-1:0] ac_addr_q, ac_addr_d;
  logic [3:0]           ac_snoop_q, ac_snoop_d;
  logic [2:0]           ac_prot_q, ac_prot_d;
  logic [IdxW-1:0]      last_grant_q, last_grant_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IdxW-1:0]      id_mem_q [MaxOutstanding];

  logic            grant_vld, accept, fifo_empty, head_rdy, cr_pop;
  logic [IdxW-1:0] grant_idx, cand, head;

  assign fifo_empty = (count_q == '0);
  assign head       = id_mem_q[rd_ptr_q];

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = IdxW'((int'(last_grant_q) + i) % NumReq);
      if (!grant_vld && req_ac_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    head_rdy = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      req_cr_valid_o[k] = !fifo_empty && cr_valid_i && (head == IdxW'(k));
      if (head == IdxW'(k)) head_rdy = req_cr_ready_i[k];
    end
  end

  assign req_cr_resp_o = cr_resp_i;

`ifdef ACE_SNOOP_ARB_ERRCHK_EN
  logic err_q;
  assign cr_ready_o = fifo_empty ? 1'b1 : head_rdy;
  assign err_o      = err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (cr_valid_i && cr_ready_o && (fifo_empty || cr_resp_i[1])) begin
      err_q <= 1'b1;
    end
  end
`else
  assign cr_ready_o = fifo_empty ? 1'b0 : head_rdy;
  assign err_o      = 1'b0;
`endif

  assign cr_pop = cr_valid_i && cr_ready_o && !fifo_empty;

  // A slot freed by a CR pop in the same cycle can be reused immediately.
  assign accept = !rst_i && grant_vld && (!ac_valid_q || ac_ready_i) &&
                  ((count_q < MaxCnt) || cr_pop);

  always_comb begin
    ac_valid_d   = ac_valid_q;
    ac_addr_d    = ac_addr_q;
    ac_snoop_d   = ac_snoop_q;
    ac_prot_d    = ac_prot_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    for (int k = 0; k < NumReq; k++) begin
      req_ac_ready_o[k] = accept && (grant_idx == IdxW'(k));
      if (accept && (grant_idx == IdxW'(k))) begin
        ac_addr_d  = req_ac_addr_i[k*AddrWidth +: AddrWidth];
        ac_snoop_d = req_ac_snoop_i[k*4 +: 4];
        ac_prot_d  = req_ac_prot_i[k*3 +: 3];
      end
    end
    if (accept) begin
      ac_valid_d   = 1'b1;
      last_grant_d = grant_idx;
      wr_ptr_d     = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end else if (ac_ready_i) begin
      ac_valid_d = 1'b0;
    end
    if (cr_pop) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    if (accept && !cr_pop)      count_d = count_q + CntW'(1);
    else if (!accept && cr_pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ac_valid_q   <= 1'b0;
      ac_addr_q    <= '0;
      ac_snoop_q   <= '0;
      ac_prot_q    <= '0;
      last_grant_q <= IdxW'(NumReq - 1);
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < MaxOutstanding; i++) id_mem_q[i] <= '0;
    end else begin
      ac_valid_q   <= ac_valid_d;
      ac_addr_q    <= ac_addr_d;
      ac_snoop_q   <= ac_snoop_d;
      ac_prot_q    <= ac_prot_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      if (accept) id_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign ac_valid_o = ac_valid_q;
  assign ac_addr_o  = ac_addr_q;
  assign ac_snoop_o = ac_snoop_q;
  assign ac_prot_o  = ac_prot_q;
endmodule

// File: doc/ace_snoop_arbiter.md
ACE_SNOOP_ARBITER -- requirements
Module: ace_snoop_arbiter

Interface
REQ-001 Param NumReq, default 2: number of snoop requesters sharing one AC/CR channel pair, range 2..8.
REQ-002 Param AddrWidth, default 64: AC address width.
REQ-003 Param MaxOutstanding, default 4: snoops in flight (issued, CR not yet returned), range 1..16.
REQ-004 Port clk_i  in  1  single clock; all state on rising edge.
REQ-005 Port rst_i  in  1  reset, synchronous, active-high.
REQ-006 Port req_ac_valid_i / req_ac_ready_o  in/out  NumReq  per-requester AC handshake.
REQ-007 Port req_ac_addr_i / req_ac_snoop_i / req_ac_prot_i  in  NumReq*AddrWidth / NumReq*4 / NumReq*3  per-requester payload, flattened, requester k at slice k.
REQ-008 Port ac_valid_o / ac_ready_i  out/in  1  shared AC handshake to snooped master.
REQ-009 Port ac_addr_o / ac_snoop_o / ac_prot_o  out  AddrWidth / 4 / 3  shared AC payload.
REQ-010 Port cr_valid_i / cr_ready_o / cr_resp_i  in/out/in  1/1/5  shared CR channel; cr_resp_i = {wasUnique, isShared, passDirty, error, dataTransfer}.
REQ-011 Port req_cr_valid_o / req_cr_ready_i  out/in  NumReq  per-requester CR handshake.
REQ-012 Port req_cr_resp_o  out  5  CR response broadcast to all requesters.
REQ-013 Port err_o  out  1  sticky protocol error flag.

Function
REQ-014 Arbitration SHALL be round-robin: priority starts at requester (last_grant+1) mod NumReq; last_grant updates only on accepted requests.
REQ-015 A request SHALL be accepted (req_ac_ready_o[k]=1 for exactly the winner) only when the output register is empty or drained this cycle (ac_ready_i && ac_valid_o) AND outstanding count < MaxOutstanding.
REQ-016 Accepted payload SHALL be registered; ac_valid_o rises the cycle after acceptance (latency 1).
REQ-017 While ac_valid_o=1 and ac_ready_i=0, ac_addr_o/ac_snoop_o/ac_prot_o SHALL hold stable; ac_valid_o SHALL not drop.
REQ-018 Back-to-back: with continuous ac_ready_i=1, a new snoop SHALL issue every cycle until the count limit.
REQ-019 On acceptance, the winner index SHALL be pushed into an in-order ID FIFO of depth MaxOutstanding; count includes the output-register entry.
REQ-020 CR routing SHALL be combinational: if FIFO non-empty, req_cr_valid_o[head]=cr_valid_i, other bits 0; cr_ready_o=req_cr_ready_i[head]; req_cr_resp_o=cr_resp_i.
REQ-021 FIFO SHALL pop on cr_valid_i && cr_ready_o; simultaneous push and pop leaves count unchanged; pointers wrap modulo MaxOutstanding.
REQ-022 FIFO empty: req_cr_valid_o=0; cr_ready_o per REQ-027.
REQ-023 DVM_COMPLETE (4'b1110) and DVM_MESSAGE (4'b1111) SHALL be arbitrated and tracked identically to other opcodes; no opcode decoding otherwise.

Reset
REQ-024 With rst_i=1 at a clock edge: ac_valid_o=0, ac payload=0, req_ac_ready_o=0, FIFO empty, count=0, last_grant=NumReq-1 (requester 0 wins first), err_o=0.
REQ-025 Reset mid-operation SHALL discard all in-flight tracking; CR beats arriving after reset are handled as FIFO-empty.
REQ-026 No output SHALL be X after the first reset edge.

Configuration
REQ-027 Macro ACE_SNOOP_ARB_ERRCHK_EN defined: with FIFO empty, cr_ready_o=1 (beat sunk) and err_o sets; err_o also sets on any handshaked CR with error bit=1; err_o clears only on reset. Undefined: cr_ready_o=0 when FIFO empty, err_o tied 0.

Verification
REQ-028 Reset, then req_ac_valid_i=2'b11 constant, ac_ready_i=1, CR held off: grants 0,1,0,1 then req_ac_ready_o=0 at count 4.
REQ-029 Req1 addr 0x1000 snoop 4'b0111 accepted, ac_ready_i=0 for 5 cycles: ac_valid_o=1 and payload 0x1000/0111 stable all 5 cycles, no further acceptance.
REQ-030 Issue req0, req1, req0; return 3 CR beats resp 5'b00001, 5'b01000, 5'b00000: req_cr_valid_o = 01, 10, 01 in order, resp matches.
REQ-031 Count=4, same cycle CR pops and req0 valid with output register draining: req0 accepted, count stays 4.
REQ-032 ERRCHK_EN defined, FIFO empty, cr_valid_i=1 resp 0: cr_ready_o=1, err_o=1 next cycle, sticky until rst_i; undefined: cr_ready_o=0, err_o=0.
REQ-033 Reset asserted with 3 outstanding: next cycle count=0, req_cr_valid_o=0, requester 0 wins first grant.
